// File: rtl/adres_cfg_pkg.sv
// Shared definitions for the ADRES configuration-chain loader.
//   cfg_state_e     : loader FSM states
//   WORD_W_DEFAULT  : default host word width
//   PE_CFG_BITS     : config bits per PE (FuncConfig, MuxA, MuxB, MuxBypass, MuxOut, const)
//   ceil_div        : word count needed to cover a chain
package adres_cfg_pkg;

  localparam int unsigned WORD_W_DEFAULT = 32;
  localparam int unsigned PE_CFG_BITS    = 46;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDone
  } cfg_state_e;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/cfg_bit_deserializer.sv
// Readback capture: collects the bits leaving the chain into host words.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_clear      : drop any partial word and pending pulse (load aborted)
//   i_shift      : chain shifts this cycle; i_bit is valid
//   i_bit        : chain ConfigOut
//   i_last       : this shift carries the final chain bit
//   o_data       : completed readback word (partial final word zero-padded)
//   o_valid      : one-cycle pulse, the cycle after the word's last bit
module cfg_bit_deserializer #(
  parameter int unsigned WORD_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_shift,
  input  logic              i_bit,
  input  logic              i_last,
  output logic [WORD_W-1:0] o_data,
  output logic              o_valid
);

  localparam int unsigned CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0] r_shreg;
  logic [WORD_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic [WORD_W-1:0] w_merged;
  logic              w_full;

  // Word being built with the current bit dropped into its slot.
  always_comb begin
    w_merged        = r_shreg;
    w_merged[r_cnt] = i_bit;
  end

  assign w_full = (r_cnt == CNT_W'(WORD_W - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt      <= '0;
      r_shreg    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (i_clear) begin
      r_cnt      <= '0;
      r_shreg    <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      if (i_shift) begin
        if (w_full || i_last) begin
          r_rd_data  <= w_merged;
          r_rd_valid <= 1'b1;
          // Cleared buffer zero-pads the next (possibly partial) word.
          r_shreg    <= '0;
          r_cnt      <= '0;
        end else begin
          r_shreg <= w_merged;
          r_cnt   <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_data  = r_rd_data;
  assign o_valid = r_rd_valid;

endmodule

// File: rtl/adres_cfg_loader.sv
// Serial configuration loader for the ADRES PE scan chain.
// Accepts host words on a valid/ready stream, shifts them LSB-first onto the chain and
// returns the chain's previous contents as readback words.
// Ports:
//   Config_Clock, Config_Reset : clock, asynchronous active-high reset
//   start, abort               : begin a load / cancel the current load
//   wr_data, wr_valid, wr_ready: host configuration word stream
//   chain_in, chain_shift_en   : chain ConfigIn and gated-clock enable (same cycle)
//   chain_out                  : chain ConfigOut
//   rd_data, rd_valid          : readback words, no backpressure
//   busy, done                 : load in progress / one-cycle completion pulse
module adres_cfg_loader
  import adres_cfg_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = PE_CFG_BITS,
  parameter int unsigned WORD_W    = WORD_W_DEFAULT
) (
  input  logic              Config_Clock,
  input  logic              Config_Reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              chain_in,
  output logic              chain_shift_en,
  input  logic              chain_out,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NUM_WORDS = ceil_div(CHAIN_LEN, WORD_W);
  localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam int unsigned AV_W      = $clog2(WORD_W + 1);
  localparam int unsigned WC_W      = $clog2(NUM_WORDS + 1);

  cfg_state_e        r_state;
  logic [WORD_W-1:0] r_shreg;
  logic [AV_W-1:0]   r_avail;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [CNT_W-1:0]  r_loaded;   // bits shifted plus bits still pending in r_shreg
  logic [WC_W-1:0]   r_words;

  logic              w_load;
  logic              w_shift;
  logic              w_ready;
  logic              w_accept;
  logic              w_last_bit;
  int unsigned       w_rem;
  logic [AV_W-1:0]   w_take;

  assign w_load     = (r_state == StLoad);
  assign w_shift    = w_load && (r_avail != '0);
  // Prefetch: take the next word while the last buffered bit shifts out.
  assign w_ready    = w_load && (r_words < WC_W'(NUM_WORDS)) &&
                      ((r_avail == '0) || ((r_avail == AV_W'(1)) && w_shift));
  assign w_accept   = w_ready && wr_valid;
  assign w_last_bit = w_shift && (r_bit_cnt == CNT_W'(CHAIN_LEN - 1));

  // Bits of the incoming word that still fit in the chain; the rest are dropped.
  always_comb begin
    w_rem  = CHAIN_LEN - 32'(r_loaded);
    w_take = (w_rem < WORD_W) ? AV_W'(w_rem) : AV_W'(WORD_W);
  end

  always_ff @(posedge Config_Clock or posedge Config_Reset) begin
    if (Config_Reset) begin
      r_state   <= StIdle;
      r_shreg   <= '0;
      r_avail   <= '0;
      r_bit_cnt <= '0;
      r_loaded  <= '0;
      r_words   <= '0;
    end else if (abort) begin
      r_state   <= StIdle;
      r_shreg   <= '0;
      r_avail   <= '0;
      r_bit_cnt <= '0;
      r_loaded  <= '0;
      r_words   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_state   <= StLoad;
            r_shreg   <= '0;
            r_avail   <= '0;
            r_bit_cnt <= '0;
            r_loaded  <= '0;
            r_words   <= '0;
          end
        end
        StLoad: begin
          if (w_shift) begin
            r_shreg   <= r_shreg >> 1;
            r_avail   <= r_avail - 1'b1;
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          // Later assignments override the shift when a prefetched word lands.
          if (w_accept) begin
            r_shreg  <= wr_data;
            r_avail  <= w_take;
            r_loaded <= r_loaded + CNT_W'(w_take);
            r_words  <= r_words + 1'b1;
          end
          if (w_last_bit) begin
            r_state <= StDone;
          end
        end
        StDone: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  cfg_bit_deserializer #(
    .WORD_W (WORD_W)
  ) u_readback (
    .i_clk   (Config_Clock),
    .i_rst   (Config_Reset),
    .i_clear (abort),
    .i_shift (w_shift),
    .i_bit   (chain_out),
    .i_last  (w_last_bit),
    .o_data  (rd_data),
    .o_valid (rd_valid)
  );

  assign wr_ready       = w_ready;
  assign chain_in       = r_shreg[0];
  assign chain_shift_en = w_shift;
  assign busy           = (r_state != StIdle);
  assign done           = (r_state == StDone);

endmodule

// File: doc/adres_cfg_loader.md
# adres_cfg_loader

Serial configuration loader for the ADRES CGRA processing-element scan chain. It accepts configuration words from the host over a valid/ready stream and shifts them LSB-first onto the chain's `ConfigIn`. It emits a clock-enable that the top level uses to gate the chain clock. While shifting, it captures the chain's previous contents from `ConfigOut` and returns them as readback words. The loader sits between the RoCC/host command path and the head of the PE config chain. The chain runs FuncConfig → MuxA → MuxB → MuxBypass → MuxOut → const, which is 46 bits per PE.

## Interface
Parameters:
- `CHAIN_LEN`, default 46: total chain bits, ≥ 1. The full 6x6 array sets it to 36 × 46.
- `WORD_W`, default 32: host word width.

Ports:
- `Config_Clock`  in  1  clock; single clock domain.
- `Config_Reset`  in  1  reset; asynchronous, active-high.
- `start`  in  1  one-cycle pulse that begins a load.
- `abort`  in  1  cancels the current load.
- `wr_data`  in  WORD_W  configuration word.
- `wr_valid`  in  1  wr_data valid.
- `wr_ready`  out  1  loader accepts wr_data this cycle.
- `chain_in`  out  1  bit driven to chain ConfigIn.
- `chain_shift_en`  out  1  enable for the gated chain clock; chain shifts on the edge ending this cycle.
- `chain_out`  in  1  chain ConfigOut.
- `rd_data`  out  WORD_W  readback word of old chain contents.
- `rd_valid`  out  1  one-cycle pulse; no backpressure.
- `busy`  out  1  a load is in progress.
- `done`  out  1  one-cycle pulse when the load completes.

## Operation
- All outputs reset to 0.
- States:
  - IDLE → LOAD on `start`.
  - LOAD → DONE when the `CHAIN_LEN`th bit shifts.
  - DONE → IDLE unconditionally.
  - `abort` in any state → IDLE next cycle.
- `busy` = (state ≠ IDLE). `done` = (state == DONE).
- Word buffer: `shreg[WORD_W]` plus `avail` = bits left in the buffer.
  - On accept: `shreg` ← wr_data and `avail` ← min(WORD_W, CHAIN_LEN − bits_shifted_or_pending).
  - Upper bits of the final partial word are discarded.
- `wr_ready` = LOAD && words_accepted < ceil(CHAIN_LEN/WORD_W) && (avail == 0 || (avail == 1 && chain_shift_en)).
  - This prefetch keeps throughput at 1 bit/cycle.
- `chain_shift_en` = LOAD && avail > 0. `chain_in` = shreg[0].
  - Each shift: shreg >>= 1, avail−−, bit_cnt++.
- Stall: if `avail == 0` and `wr_valid` is low, `chain_shift_en` stays 0 and the chain holds.
- Readback:
  - In each shifting cycle, sample `chain_out` into `rd_shreg` at position rd_cnt.
  - When 32 bits have been captured, or the final bit of the chain has been captured, register the result to `rd_data` and pulse `rd_valid` the next cycle.
  - A partial final word is zero-padded in its upper bits.
- `start` while busy: ignored. `start` and `abort` together: abort wins.
- `wr_valid` outside LOAD: ignored, and `wr_ready` stays 0.
- `abort` or reset mid-load: counters and buffer clear, and no `done` or further `rd_valid` is produced.
  - The chain keeps the partially shifted contents, which are undefined as a configuration.

## Timing
- With `start` at cycle 0 and wr_valid held high, for `CHAIN_LEN`=46:
  - Cycle 1: LOAD, wr_ready=1, word 0 is accepted.
  - Cycles 2–33: word 0 shifts.
  - Cycle 33: word 1 is accepted (prefetch).
  - Cycles 34–47: the 14 bits of word 1 shift.
  - Cycle 34: rd_valid for readback word 0.
  - Cycle 48: done, plus rd_valid for readback word 1.
  - Cycle 49: IDLE.
- In general, done arrives at cycle CHAIN_LEN+2 plus the number of stall cycles.
- chain_in and chain_shift_en are valid in the same cycle; the chain samples on the rising edge ending that cycle.

## Structure
- Package `adres_cfg_pkg`:
  - State enum (IDLE, LOAD, DONE).
  - `WORD_W` default.
  - `PE_CFG_BITS` = 46.
  - ceil-div function for the word count.
- One natural sub-module: `cfg_bit_deserializer`, which implements the readback capture (bit counter, shreg, rd_valid pulse). The serializer stays inline in the FSM.

## Test plan
- Load with CHAIN_LEN=46, words 0x89ABCDEF and 0x0000_1234 back-to-back:
  - chain_in sequence is the LSB-first bits of 0x89ABCDEF, then the 14 LSBs of 0x1234.
  - done at cycle 48.
  - A chain model reads back the same 46 bits.
- Second load with words 0 and 0 after the previous test:
  - rd_data = 0x89ABCDEF at cycle 34.
  - rd_data = 0x1234 & 0x3FFF at cycle 48.
- wr_valid low for 5 cycles after the first word drains:
  - chain_shift_en stays 0 for those 5 cycles.
  - done is delayed to cycle 53.
  - No bits are lost.
- abort at cycle 20:
  - busy=0 at cycle 21.
  - No done or rd_valid afterwards.
  - A subsequent start performs a complete load.
- start pulses at cycles 10 and 40 during a load, and wr_valid high while IDLE:
  - Both start pulses are ignored.
  - wr_ready stays 0 while IDLE.
  - Exactly 2 words are accepted.
- Config_Reset asserted asynchronously mid-shift:
  - All outputs go to 0 immediately.
  - State is IDLE after reset is released.
